// File: rtl/dehaze_pkg.sv
// Shared types and geometry defaults for the dehaze window scheduling path.
package dehaze_pkg;

  localparam int IMG_W_DEF = 100;
  localparam int IMG_H_DEF = 100;

  // Bit width needed to hold 0..limit-1, never less than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

  localparam int POS_W = cnt_w(IMG_W_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PREFILL,
    ST_STREAM,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/window_scheduler_if.sv
// Control/status bundle between the window scheduler and its frame controller.
interface window_scheduler_if;
  import dehaze_pkg::*;

  logic             start;
  logic             abort;
  logic             buf_rdy;
  logic             out_ready;
  logic             buf_rst;
  logic             buf_rd;
  logic             win_valid;
  logic [POS_W-1:0] win_row;
  logic [POS_W-1:0] win_col;
  logic             sof;
  logic             eol;
  logic             frame_done;
  logic             busy;
  logic             err_tmo;

  modport master (
    output start, abort, buf_rdy, out_ready,
    input  buf_rst, buf_rd, win_valid, win_row, win_col,
           sof, eol, frame_done, busy, err_tmo
  );

  modport slave (
    input  start, abort, buf_rdy, out_ready,
    output buf_rst, buf_rd, win_valid, win_row, win_col,
           sof, eol, frame_done, busy, err_tmo
  );

endinterface

// File: rtl/window_scheduler_pos_counter.sv
// Raster row/column position counter: advances on en, wraps at the frame edges.
module pos_counter
  import dehaze_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  localparam int COL_W = cnt_w(IMG_W),
  localparam int ROW_W = cnt_w(IMG_H)
) (
  input  logic             gen_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last_col,
  output logic             last_row
);

  assign last_col = (col == COL_W'(IMG_W - 1));
  assign last_row = (row == ROW_W'(IMG_H - 1));

  always_ff @(posedge gen_clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/window_scheduler.sv
// Frame sequencer for a 3x3 line-buffer window source: clear, prefill, then
// stream one window per downstream-ready cycle in raster order.
module window_scheduler
  import dehaze_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int PREFILL_TMO = 1023
) (
  input  logic              gen_clk,
  input  logic              rst_n,
  window_scheduler_if.slave bus
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam int TMO_W = cnt_w(PREFILL_TMO);

  sched_state_t     state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             clr_cnt;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last_col;
  logic             last_row;
  logic             rd;
  logic             pos_clr;
  logic             frame_end;

  // The strobe follows out_ready directly so a stalled consumer never loses a window.
  assign rd         = (state == ST_STREAM) & bus.out_ready;
  assign bus.buf_rd = rd;
  assign frame_end  = rd & last_col & last_row;
  assign pos_clr    = (state == ST_PREFILL) & bus.buf_rdy;

  pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .gen_clk  (gen_clk),
    .rst_n    (rst_n),
    .clr      (pos_clr),
    .en       (rd),
    .row      (row),
    .col      (col),
    .last_col (last_col),
    .last_row (last_row)
  );

  always_ff @(posedge gen_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      tmo_cnt        <= '0;
      clr_cnt        <= 1'b0;
      bus.buf_rst    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err_tmo    <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      if (bus.abort && state != ST_IDLE) begin
        state       <= ST_IDLE;
        bus.busy    <= 1'b0;
        bus.buf_rst <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              state       <= ST_CLEAR;
              bus.busy    <= 1'b1;
              bus.buf_rst <= 1'b1;
              clr_cnt     <= 1'b0;
              bus.err_tmo <= 1'b0;
            end
          end
          ST_CLEAR: begin
            if (clr_cnt) begin
              state       <= ST_PREFILL;
              bus.buf_rst <= 1'b0;
              tmo_cnt     <= '0;
            end else begin
              clr_cnt <= 1'b1;
            end
          end
          ST_PREFILL: begin
            if (bus.buf_rdy) begin
              state <= ST_STREAM;
            end else if (tmo_cnt == TMO_W'(PREFILL_TMO - 1)) begin
              state       <= ST_IDLE;
              bus.busy    <= 1'b0;
              bus.err_tmo <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          ST_STREAM: begin
            if (frame_end) state <= ST_DONE;
          end
          ST_DONE: begin
            state          <= ST_IDLE;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b1;
          end
          default: begin
            state       <= ST_IDLE;
            bus.busy    <= 1'b0;
            bus.buf_rst <= 1'b0;
          end
        endcase
      end
    end
  end

  // Window outputs: registered one cycle behind the strobe that produced them.
  always_ff @(posedge gen_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.win_valid <= 1'b0;
      bus.win_row   <= '0;
      bus.win_col   <= '0;
      bus.sof       <= 1'b0;
      bus.eol       <= 1'b0;
    end else begin
      bus.win_valid <= rd;
      bus.sof       <= rd & (row == '0) & (col == '0);
      bus.eol       <= rd & last_col;
      if (rd) begin
        bus.win_row <= POS_W'(row);
        bus.win_col <= POS_W'(col);
      end
    end
  end

endmodule

// File: tb/tb_window_scheduler.sv
// Scoreboard bench for window_scheduler: randomized downstream stalls against a
// raster-order reference of every window a frame must deliver.
module tb_window_scheduler;
  import dehaze_pkg::*;

  localparam int W   = 100;
  localparam int H   = 100;
  localparam int TMO = 1023;

  logic gen_clk = 1'b0;
  logic rst_n   = 1'b0;

  window_scheduler_if wif();

  window_scheduler #(
    .IMG_W       (W),
    .IMG_H       (H),
    .PREFILL_TMO (TMO)
  ) dut (
    .gen_clk (gen_clk),
    .rst_n   (rst_n),
    .bus     (wif.slave)
  );

  always #5 gen_clk = ~gen_clk;

  typedef struct {
    int r;
    int c;
    bit sof;
    bit eol;
  } win_t;

  win_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int win_cnt, rd_cnt, fd_cnt, sof_cnt, eol_cnt, bufrst_cyc, rd_bad, last_win_cyc;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the reference on every presented window.
  always @(negedge gen_clk) begin
    win_t e;
    cyc++;
    if (rst_n) begin
      if (wif.buf_rd) rd_cnt++;
      if (wif.buf_rd && !wif.out_ready) rd_bad++;
      if (wif.buf_rst) bufrst_cyc++;
      if (wif.win_valid) begin
        win_cnt++;
        last_win_cyc = cyc;
        if (wif.sof) sof_cnt++;
        if (wif.eol) eol_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL window_extra: got (%0d,%0d), expected no window",
                   wif.win_row, wif.win_col);
        end else begin
          e = exp_q.pop_front();
          if (int'(wif.win_row) != e.r || int'(wif.win_col) != e.c ||
              wif.sof != e.sof || wif.eol != e.eol) begin
            errors++;
            $display("FAIL window: got (%0d,%0d) sof=%0d eol=%0d, expected (%0d,%0d) sof=%0d eol=%0d",
                     wif.win_row, wif.win_col, wif.sof, wif.eol, e.r, e.c, e.sof, e.eol);
          end
        end
      end
      if (wif.frame_done) begin
        fd_cnt++;
        chk("frame_done_latency", cyc - last_win_cyc, 1);
      end
    end
  end

  task automatic tick();
    @(posedge gen_clk);
    #1;
  endtask

  task automatic new_frame(input bit with_windows);
    exp_q.delete();
    win_cnt = 0; rd_cnt = 0; fd_cnt = 0; sof_cnt = 0;
    eol_cnt = 0; bufrst_cyc = 0; rd_bad = 0;
    if (with_windows)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          exp_q.push_back('{r: r, c: c, sof: (r == 0 && c == 0), eol: (c == W - 1)});
    wif.start = 1'b1;
    tick();
    wif.start = 1'b0;
  endtask

  task automatic stream(input int pct, input int bound, input int rdy_dly, input bit mid_start);
    int n = 0;
    repeat (rdy_dly) tick();
    wif.buf_rdy = 1'b1;
    while (wif.busy && n < bound) begin
      wif.out_ready = (int'($urandom_range(0, 99)) < pct);
      wif.start     = mid_start && (n == 3000);
      tick();
      n++;
    end
    wif.start = 1'b0;
    chk("frame_within_budget", (n < bound), 1);
    wif.buf_rdy   = 1'b0;
    wif.out_ready = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_full_frame(input string tag);
    chk({tag, "_windows"}, win_cnt, W * H);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_frame_done"}, fd_cnt, 1);
    chk({tag, "_buf_rst_cycles"}, bufrst_cyc, 2);
    chk({tag, "_sof_count"}, sof_cnt, 1);
    chk({tag, "_eol_count"}, eol_cnt, H);
    chk({tag, "_rd_without_ready"}, rd_bad, 0);
    chk({tag, "_busy_after"}, wif.busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_buf_rst"}, wif.buf_rst, 0);
    chk({tag, "_buf_rd"}, wif.buf_rd, 0);
    chk({tag, "_win_valid"}, wif.win_valid, 0);
    chk({tag, "_win_row"}, wif.win_row, 0);
    chk({tag, "_win_col"}, wif.win_col, 0);
    chk({tag, "_sof"}, wif.sof, 0);
    chk({tag, "_eol"}, wif.eol, 0);
    chk({tag, "_frame_done"}, wif.frame_done, 0);
    chk({tag, "_busy"}, wif.busy, 0);
    chk({tag, "_err_tmo"}, wif.err_tmo, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    wif.start = 1'b0; wif.abort = 1'b0; wif.buf_rdy = 1'b0; wif.out_ready = 1'b0;
    repeat (3) @(posedge gen_clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Full frame, downstream always ready.
    new_frame(1);
    wif.out_ready = 1'b1;
    stream(100, 12000, 5, 1'b0);
    check_full_frame("frame_ready");

    // Random stalls, plus a start pulse mid-stream that must be ignored.
    new_frame(1);
    stream(50, 40000, 4, 1'b1);
    check_full_frame("frame_stall");

    // Prefill never completes.
    new_frame(0);
    n = 0;
    while (!wif.err_tmo && n < 3000) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, 2 + TMO);
    chk("tmo_busy", wif.busy, 0);
    chk("tmo_frame_done", fd_cnt, 0);
    chk("tmo_windows", win_cnt, 0);
    repeat (5) tick();
    chk("tmo_sticky", wif.err_tmo, 1);

    // Abort on the strobe that delivers window (40,17).
    new_frame(1);
    chk("err_tmo_cleared_by_start", wif.err_tmo, 0);
    wif.out_ready = 1'b1;
    repeat (3) tick();
    wif.buf_rdy = 1'b1;
    n = 0;
    while (!(wif.buf_rd && rd_cnt == 40 * W + 17) && n < 6000) begin
      tick();
      n++;
    end
    chk("abort_point_reached", (n < 6000), 1);
    wif.abort = 1'b1;
    tick();
    wif.abort   = 1'b0;
    wif.buf_rdy = 1'b0;
    chk("abort_busy", wif.busy, 0);
    chk("abort_buf_rd", wif.buf_rd, 0);
    tick();
    chk("abort_win_valid_second", wif.win_valid, 0);
    repeat (5) tick();
    chk("abort_windows", win_cnt, 40 * W + 18);
    chk("abort_frame_done", fd_cnt, 0);
    wif.out_ready = 1'b0;

    new_frame(1);
    stream(75, 40000, 2, 1'b0);
    check_full_frame("after_abort");

    // Asynchronous reset in the middle of streaming.
    new_frame(1);
    wif.out_ready = 1'b1;
    repeat (3) tick();
    wif.buf_rdy = 1'b1;
    n = 0;
    while (rd_cnt < 500 && n < 3000) begin
      tick();
      n++;
    end
    chk("reset_point_reached", (n < 3000), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    tick();
    wif.buf_rdy   = 1'b0;
    wif.out_ready = 1'b0;
    rst_n = 1'b1;
    tick();

    new_frame(1);
    stream(100, 15000, 5, 1'b0);
    check_full_frame("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
